// File: rtl/fib_stack_engine.sv
`default_nettype none
// ============================================================================
// Module   : fib_stack_engine
// Purpose  : Iterative Fibonacci engine that emulates fib(x-1)+fib(x-2) with an
//            explicit stack. Optional cycle counter port: FIB_CYCLE_COUNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fib_stack_engine #(
  parameter int WIDTH = 16,
  parameter int NW    = 5,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NW-1:0]    n,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             ovf,
  output logic             err
`ifdef FIB_CYCLE_COUNT_EN
  ,
  output logic [31:0]      cycles
`endif
);

  localparam int SPW  = $clog2(DEPTH + 1);
  localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_POP   = 3'd1,
    S_EVAL  = 3'd2,
    S_PUSH2 = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [NW-1:0]    stack_q [DEPTH];
  logic [SPW-1:0]   sp_q, sp_d;
  logic [NW-1:0]    x_q, x_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;

  logic             wr_en;
  logic [IDXW-1:0]  wr_idx;
  logic [NW-1:0]    wr_data;
  logic [SPW-1:0]   sp_m1;
  logic [WIDTH:0]   sum;
  logic             full;
  logic             leaf;

  assign sp_m1 = sp_q - SPW'(1);
  assign full  = (sp_q == SPW'(DEPTH));
  // x < 2 means only bit 0 can be set, so the leaf value is x[0]
  assign leaf  = ((x_q >> 1) == '0);
  assign sum   = {1'b0, acc_q} + {{WIDTH{1'b0}}, x_q[0]};

  always_comb begin
    state_d  = state_q;
    sp_d     = sp_q;
    x_d      = x_q;
    acc_d    = acc_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
    wr_en    = 1'b0;
    wr_idx   = sp_q[IDXW-1:0];
    wr_data  = x_q - NW'(1);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          wr_en   = 1'b1;
          wr_idx  = '0;
          wr_data = n;
          sp_d    = SPW'(1);
          acc_d   = '0;
          ovf_d   = 1'b0;
          err_d   = 1'b0;
          state_d = S_POP;
        end
      end
      S_POP: begin
        if (sp_q == '0) begin
          result_d = acc_q;
          state_d  = S_DONE;
        end else begin
          x_d     = stack_q[sp_m1[IDXW-1:0]];
          sp_d    = sp_m1;
          state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        if (leaf) begin
          acc_d   = sum[WIDTH-1:0];
          ovf_d   = ovf_q | sum[WIDTH];
          state_d = S_POP;
        end else if (full) begin
          err_d    = 1'b1;
          result_d = '0;
          state_d  = S_DONE;
        end else begin
          wr_en   = 1'b1;
          sp_d    = sp_q + SPW'(1);
          state_d = S_PUSH2;
        end
      end
      S_PUSH2: begin
        if (full) begin
          err_d    = 1'b1;
          result_d = '0;
          state_d  = S_DONE;
        end else begin
          wr_en   = 1'b1;
          wr_data = x_q - NW'(2);
          sp_d    = sp_q + SPW'(1);
          state_d = S_POP;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sp_q     <= '0;
      x_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sp_q     <= sp_d;
      x_q      <= x_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
    end
  end

  // Stack storage carries no reset; its contents are meaningless until pushed
  always_ff @(posedge clk) begin
    if (wr_en) begin
      stack_q[wr_idx] <= wr_data;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign result = result_q;
  assign ovf    = ovf_q;
  assign err    = err_q;

`ifdef FIB_CYCLE_COUNT_EN
  logic [31:0] cycles_q, cycles_d;

  // The accepting edge counts as the first elapsed cycle, so the value seen
  // during DONE equals the start-to-done latency
  always_comb begin
    cycles_d = cycles_q;
    if (state_q == S_IDLE) begin
      if (start) begin
        cycles_d = 32'd1;
      end
    end else if (state_q != S_DONE) begin
      if (cycles_q != '1) begin
        cycles_d = cycles_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycles_q <= '0;
    end else begin
      cycles_q <= cycles_d;
    end
  end

  assign cycles = cycles_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fib_stack_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_fib_stack_engine
// Purpose  : Self-checking bench for fib_stack_engine (default and small-stack
//            instances); cycle counter checked when FIB_CYCLE_COUNT_EN is set.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fib_stack_engine;

  localparam int WA = 7;
  localparam int NW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_a = 1'b0, start_b = 1'b0;
  logic [NW-1:0] n_a = '0, n_b = '0;
  logic          busy_a, done_a, ovf_a, err_a;
  logic          busy_b, done_b, ovf_b, err_b;
  logic [WA-1:0] result_a;
  logic [15:0]   result_b;
  logic [31:0]   cycles_a, cycles_b;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  // Expected-behaviour model of instance A
  bit      m_active = 1'b0;
  int      m_start  = 0;
  int      m_t      = 0;
  longint  m_res    = 0;
  longint  m_ovf    = 0;
  longint  m_cyc    = 0;
  int      obs_k    = -1;

  fib_stack_engine #(.WIDTH(WA), .NW(NW), .DEPTH(16)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .n(n_a),
    .busy(busy_a), .done(done_a), .result(result_a), .ovf(ovf_a), .err(err_a)
`ifdef FIB_CYCLE_COUNT_EN
    , .cycles(cycles_a)
`endif
  );

  fib_stack_engine #(.WIDTH(16), .NW(NW), .DEPTH(3)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .n(n_b),
    .busy(busy_b), .done(done_b), .result(result_b), .ovf(ovf_b), .err(err_b)
`ifdef FIB_CYCLE_COUNT_EN
    , .cycles(cycles_b)
`endif
  );

`ifndef FIB_CYCLE_COUNT_EN
  assign cycles_a = '0;
  assign cycles_b = '0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint fib(input int k);
    longint a = 0, b = 1, t;
    for (int i = 0; i < k; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Latency from the number of leaves of the recursion tree
  function automatic int lat(input int k);
    longint leaves = (k == 0) ? 1 : fib(k + 1);
    return int'(5 * leaves - 1);
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      int  k;
      bit  eb, ed;
      k  = cyc - m_start + 1;
      eb = m_active && (k >= 1) && (k <= m_t);
      ed = m_active && (k == m_t);
      chk("busy", busy_a, eb);
      chk("done", done_a, ed);
      if (done_a) obs_k = k;
      if (!eb || ed) begin
        chk("result", result_a, m_res);
        chk("ovf", ovf_a, m_ovf);
        chk("err", err_a, 0);
`ifdef FIB_CYCLE_COUNT_EN
        chk("cycles", cycles_a, m_cyc);
`endif
      end
    end
  end

  // Starts instance A with n, optionally pulses an ignored start or resets
  task automatic run_a(input int nv, input int lit_t, input longint lit_res,
                       input int ign_at, input int rst_at);
    @(posedge clk); #2;
    start_a = 1'b1;
    n_a     = NW'(nv);
    @(posedge clk); #2;
    start_a  = 1'b0;
    n_a      = '0;
    obs_k    = -1;
    m_active = 1'b1;
    m_start  = cyc;
    m_t      = lat(nv);
    m_res    = fib(nv) % (64'sd1 << WA);
    m_ovf    = (fib(nv) >= (64'sd1 << WA)) ? 1 : 0;
    m_cyc    = m_t;
    for (int i = 1; i < m_t; i++) begin
      if (i == rst_at) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst      = 1'b0;
        m_active = 1'b0;
        m_res    = 0;
        m_ovf    = 0;
        m_cyc    = 0;
        return;
      end
      if (i == ign_at) begin
        start_a = 1'b1;
        n_a     = NW'(3);
      end else begin
        start_a = 1'b0;
      end
      @(posedge clk); #2;
    end
    start_a = 1'b0;
    @(negedge clk); #1;
    chk($sformatf("done_cycle_n%0d", nv), obs_k, lit_t);
    chk($sformatf("result_n%0d", nv), result_a, lit_res);
  endtask

  // Small-stack instance: returns done cycle, pulse count and final outputs
  task automatic run_b(input int nv, input int lit_t, input longint lit_res,
                       input bit lit_err);
    int s, dk, dcnt;
    @(posedge clk); #2;
    start_b = 1'b1;
    n_b     = NW'(nv);
    @(posedge clk); #2;
    start_b = 1'b0;
    s    = cyc;
    dk   = -1;
    dcnt = 0;
    repeat (60) begin
      @(negedge clk);
      if (done_b) begin
        dcnt++;
        if (dk < 0) dk = cyc - s + 1;
        chk($sformatf("b_result_n%0d", nv), result_b, lit_res);
        chk($sformatf("b_err_n%0d", nv), err_b, lit_err);
        chk($sformatf("b_ovf_n%0d", nv), ovf_b, 0);
      end
    end
    chk($sformatf("b_done_cycle_n%0d", nv), dk, lit_t);
    chk($sformatf("b_done_pulses_n%0d", nv), dcnt, 1);
    chk($sformatf("b_busy_after_n%0d", nv), busy_b, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);

    run_a(0, 4, 0, 0, 0);
    run_a(1, 4, 1, 0, 0);
    run_a(10, 444, 55, 0, 0);
    run_a(11, 719, 89, 0, 0);
    run_a(12, 1164, 16, 0, 0);
    chk("ovf_after_wrap", ovf_a, 1);
    run_a(5, 39, 5, 0, 0);
    chk("ovf_cleared", ovf_a, 0);
    run_a(2, 9, 1, 0, 0);
    repeat (3) @(posedge clk);
    run_a(7, 104, 13, 5, 0);
    repeat (3) @(posedge clk);
    run_a(7, 104, 13, 0, 20);
    repeat (40) @(posedge clk);
    #2;
    chk("no_done_after_reset", obs_k, -1);
    chk("result_after_reset", result_a, 0);

    run_b(6, 10, 0, 1'b1);
    run_b(4, 24, 3, 1'b0);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
